udp_mode_recv: RTL and testbench
================================

# udp_mode_recv

Receive-side counterpart of the daughter-board mode-command sender. It sits on the mother board behind the UDP stack's application receive interface. It collects each UDP payload, validates it as a 2-byte big-endian mode command (0x0001 camera, 0x0003 SD card), and emits a one-cycle command strobe plus a held current-mode flag. Malformed payloads are dropped and counted.

## Interface
- CMD_CAMERA, 16'h0001, camera-mode command code
- CMD_SD, 16'h0003, SD-card-mode command code
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- app_rx_data_valid  input  1  payload byte strobe; one packet is one contiguous run of high cycles
- app_rx_data  input  8  payload byte, valid when app_rx_data_valid=1
- app_rx_data_length  input  16  UDP payload length; stable while app_rx_data_valid=1
- mode_cmd  output  16  last accepted command, big-endian reassembled
- mode_cmd_valid  output  1  one-cycle pulse when mode_cmd is updated
- mode_cam  output  1  current mode: 1 = camera, 0 = SD card
- cmd_err  output  1  one-cycle pulse when a packet is rejected
- err_cnt  output  8  count of rejected packets, saturating at 255

## Operation
- Reset values: mode_cmd=16'h0000, mode_cmd_valid=0, mode_cam=1, cmd_err=0, err_cnt=0, state=IDLE, byte_cnt=0, internal shift/len registers 0.
- Two states:
  - IDLE: on app_rx_data_valid=1, latch app_rx_data into shift[15:8], latch app_rx_data_length into len_reg, set byte_cnt=1, go to RECV.
  - RECV: while app_rx_data_valid=1, if byte_cnt==1 latch app_rx_data into shift[7:0]. Increment byte_cnt, saturating at 3; later bytes are discarded. When app_rx_data_valid=0, evaluate the packet and go to IDLE.
- Evaluation passes only if byte_cnt==2, len_reg==2, and the code filter passes (see Configuration).
  - Pass: mode_cmd<=shift and mode_cmd_valid<=1. If shift==CMD_CAMERA, mode_cam<=1. If shift==CMD_SD, mode_cam<=0. Any other code leaves mode_cam unchanged.
  - Fail: cmd_err<=1, and err_cnt<=err_cnt+1 unless it is already 255. mode_cmd and mode_cam are unchanged.
- mode_cmd_valid and cmd_err are default-low every cycle and are never high together.
- A repeated identical command is still pulsed.

## Timing
- Let edge E0 sample the final payload byte. Edge E1 samples app_rx_data_valid=0. mode_cmd_valid or cmd_err is high for exactly the cycle after E1; mode_cmd and mode_cam update at E1.
- Minimum inter-packet gap is one low cycle. A new packet whose first byte is sampled at E2 is captured normally by IDLE.
- A 1-byte packet fails: byte_cnt=1.
- A packet of 3 or more bytes fails: byte_cnt saturates at 3.
- A length-field mismatch fails, including a 2-byte run with length≠2.
- Reset mid-packet: the partial packet is discarded with no pulse and no error count. If app_rx_data_valid is still high when reset releases, the remaining bytes are treated as a new packet and are evaluated normally.
- No backpressure: every byte is accepted in its cycle.

## Configuration
- Macro UDP_MODE_RECV_FILTER_EN.
- Defined: the code filter passes only CMD_CAMERA or CMD_SD. Any other 2-byte code is a failure: cmd_err pulses and err_cnt increments.
- Undefined: the code filter always passes. Any well-formed 2-byte command pulses mode_cmd_valid with mode_cmd set. mode_cam still changes only on CMD_CAMERA or CMD_SD.

## Test plan
- Reset, then send bytes 0x00,0x03 with length 2 → mode_cmd=0x0003, one-cycle mode_cmd_valid one cycle after the byte run ends, mode_cam=0, err_cnt=0.
- Send 0x00,0x01 with length 2, then after a 1-cycle gap send 0x00,0x03 → two pulses, mode_cam 1 then 0, mode_cmd ends at 0x0003.
- Send a 1-byte packet 0x00 with length 1, then a 3-byte packet 0x00,0x01,0x55 with length 3 → two cmd_err pulses, err_cnt=2, mode_cmd unchanged, no mode_cmd_valid.
- Send 0x12,0x34 with length 2 → with FILTER_EN: cmd_err pulse and err_cnt+1. Without it: mode_cmd=0x1234 with a pulse, and mode_cam unchanged.
- Send 256 bad packets → err_cnt holds at 255, and cmd_err pulses on every packet.
- Assert rst_n low after the first byte of 0x00,0x03 → no pulse, all outputs at reset values, and the next valid packet is accepted normally.

Source files
------------

// File: rtl/udp_mode_recv_if.sv
// UDP application receive-side byte stream: payload strobe, byte and payload length.
// The stack drives the master side and udp_mode_recv takes the slave side.
interface udp_mode_recv_if;
  logic        app_rx_data_valid;
  logic [7:0]  app_rx_data;
  logic [15:0] app_rx_data_length;

  modport master (
    output app_rx_data_valid,
    output app_rx_data,
    output app_rx_data_length
  );

  modport slave (
    input app_rx_data_valid,
    input app_rx_data,
    input app_rx_data_length
  );
endinterface

// File: rtl/udp_mode_recv.sv
// Collects a UDP payload, validates it as a 2-byte big-endian mode command and reports it.
// Define UDP_MODE_RECV_FILTER_EN to accept only the camera and SD-card command codes.
module udp_mode_recv (
  input  logic                  clk,
  input  logic                  rst_n,
  udp_mode_recv_if.slave        rx,
  output logic [15:0]           mode_cmd,
  output logic                  mode_cmd_valid,
  output logic                  mode_cam,
  output logic                  cmd_err,
  output logic [7:0]            err_cnt
);

  localparam logic [15:0] CMD_CAMERA = 16'h0001;
  localparam logic [15:0] CMD_SD     = 16'h0003;

  typedef enum logic {IDLE, RECV} state_t;

  state_t      state;
  logic [1:0]  byte_cnt;
  logic [15:0] shift;
  logic [15:0] len_reg;
  logic        code_ok;
  logic        pkt_ok;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A count of 3 stands for "three or more bytes", so later bytes cannot wrap it back to 2.
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  always_comb begin
`ifdef UDP_MODE_RECV_FILTER_EN
    code_ok = (shift == CMD_CAMERA) || (shift == CMD_SD);
`else
    code_ok = 1'b1;
`endif
    pkt_ok = (byte_cnt == 2'd2) && (len_reg == 16'd2) && code_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      byte_cnt       <= 2'd0;
      shift          <= 16'h0000;
      len_reg        <= 16'h0000;
      mode_cmd       <= 16'h0000;
      mode_cmd_valid <= 1'b0;
      mode_cam       <= 1'b1;
      cmd_err        <= 1'b0;
      err_cnt        <= 8'd0;
    end else begin
      mode_cmd_valid <= 1'b0;
      cmd_err        <= 1'b0;
      case (state)
        IDLE: begin
          if (rx.app_rx_data_valid) begin
            shift[15:8] <= rx.app_rx_data;
            len_reg     <= rx.app_rx_data_length;
            byte_cnt    <= 2'd1;
            state       <= RECV;
          end
        end
        RECV: begin
          if (rx.app_rx_data_valid) begin
            if (byte_cnt == 2'd1) shift[7:0] <= rx.app_rx_data;
            byte_cnt <= sat_inc2(byte_cnt);
          end else begin
            // First low cycle ends the packet: judge it and report exactly once.
            state    <= IDLE;
            byte_cnt <= 2'd0;
            if (pkt_ok) begin
              mode_cmd       <= shift;
              mode_cmd_valid <= 1'b1;
              if (shift == CMD_CAMERA) mode_cam <= 1'b1;
              else if (shift == CMD_SD) mode_cam <= 1'b0;
            end else begin
              cmd_err <= 1'b1;
              err_cnt <= sat_inc8(err_cnt);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_mode_recv.sv
// Self-checking bench for udp_mode_recv: directed packets plus random packets against a packet-level model.
module tb_udp_mode_recv;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  udp_mode_recv_if rx();

  logic [15:0] mode_cmd;
  logic        mode_cmd_valid;
  logic        mode_cam;
  logic        cmd_err;
  logic [7:0]  err_cnt;

  udp_mode_recv dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx             (rx),
    .mode_cmd       (mode_cmd),
    .mode_cmd_valid (mode_cmd_valid),
    .mode_cam       (mode_cam),
    .cmd_err        (cmd_err),
    .err_cnt        (err_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Packet-level reference state
  logic [15:0] m_cmd = 16'h0000;
  logic        m_cam = 1'b1;
  int          m_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mode_cmd"}, {16'h0, mode_cmd}, 32'h0);
    chk({tag, "_valid"}, {31'h0, mode_cmd_valid}, 32'h0);
    chk({tag, "_mode_cam"}, {31'h0, mode_cam}, 32'h1);
    chk({tag, "_cmd_err"}, {31'h0, cmd_err}, 32'h0);
    chk({tag, "_err_cnt"}, {24'h0, err_cnt}, 32'h0);
  endtask

  task automatic send_pkt(input logic [7:0] b[$], input logic [15:0] len);
    logic        pass;
    logic [15:0] code;
    foreach (b[i]) begin
      @(negedge clk);
      rx.app_rx_data_valid  = 1'b1;
      rx.app_rx_data        = b[i];
      rx.app_rx_data_length = len;
      @(posedge clk); #1;
      chk("no_pulse_in_run", {30'h0, mode_cmd_valid, cmd_err}, 32'h0);
    end
    @(negedge clk);
    rx.app_rx_data_valid = 1'b0;
    rx.app_rx_data       = 8'($urandom);
    code = (b.size() >= 2) ? {b[0], b[1]} : 16'h0000;
    pass = (b.size() == 2) && (len == 16'd2);
`ifdef UDP_MODE_RECV_FILTER_EN
    pass = pass && ((code == 16'h0001) || (code == 16'h0003));
`endif
    if (pass) begin
      m_cmd = code;
      if (code == 16'h0001) m_cam = 1'b1;
      else if (code == 16'h0003) m_cam = 1'b0;
    end else if (m_err < 255) begin
      m_err++;
    end
    @(posedge clk); #1;
    chk("mode_cmd_valid", {31'h0, mode_cmd_valid}, {31'h0, pass});
    chk("cmd_err", {31'h0, cmd_err}, {31'h0, !pass});
    chk("mode_cmd", {16'h0, mode_cmd}, {16'h0, m_cmd});
    chk("mode_cam", {31'h0, mode_cam}, {31'h0, m_cam});
    chk("err_cnt", {24'h0, err_cnt}, 32'(m_err));
  endtask

  initial begin
    logic [7:0]  q[$];
    int          n;
    int          sel;
    logic [15:0] len;

    rx.app_rx_data_valid  = 1'b0;
    rx.app_rx_data        = 8'h00;
    rx.app_rx_data_length = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // SD command, then camera/SD back to back with one-cycle gap
    q = {8'h00, 8'h03}; send_pkt(q, 16'd2);
    q = {8'h00, 8'h01}; send_pkt(q, 16'd2);
    q = {8'h00, 8'h03}; send_pkt(q, 16'd2);
    // Repeated identical command still pulses
    q = {8'h00, 8'h03}; send_pkt(q, 16'd2);

    // Short and long packets
    q = {8'h00}; send_pkt(q, 16'd1);
    q = {8'h00, 8'h01, 8'h55}; send_pkt(q, 16'd3);
    // Length mismatch on a 2-byte run, and a 1-byte run claiming length 2
    q = {8'h00, 8'h01}; send_pkt(q, 16'd3);
    q = {8'h00}; send_pkt(q, 16'd2);
    // Unknown code: filtered or accepted depending on build
    q = {8'h12, 8'h34}; send_pkt(q, 16'd2);

    // Random packets
    for (int k = 0; k < 60; k++) begin
      q = {};
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      sel = $urandom_range(0, 3);
      if (n == 2 && sel == 0) q = {8'h00, 8'h01};
      if (n == 2 && sel == 1) q = {8'h00, 8'h03};
      len = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 5)) : 16'(n);
      send_pkt(q, len);
    end

    // Saturation of the error counter
    for (int k = 0; k < 256; k++) begin
      q = {8'hAA};
      send_pkt(q, 16'd1);
    end
    chk("err_cnt_saturated", {24'h0, err_cnt}, 32'd255);

    // Reset in the middle of a packet
    @(negedge clk);
    rx.app_rx_data_valid  = 1'b1;
    rx.app_rx_data        = 8'h00;
    rx.app_rx_data_length = 16'd2;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    rx.app_rx_data_valid = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("midreset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    m_cmd = 16'h0000;
    m_cam = 1'b1;
    m_err = 0;
    @(posedge clk); #1;
    chk("post_reset_quiet", {30'h0, mode_cmd_valid, cmd_err}, 32'h0);
    q = {8'h00, 8'h03}; send_pkt(q, 16'd2);
    q = {8'h00, 8'h01}; send_pkt(q, 16'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no end expected end of stimulus");
    $fatal(1, "timeout");
  end

endmodule
